// File: rtl/uart_rx_ext.sv
// ---------------------------------------------------------------------------
// uart_rx_ext -- oversampling UART receiver with tagged receive FIFO
//
// Receives asynchronous serial frames (5..8 data bits, optional odd/even
// parity, one or two stop bits) using OSR baud_tick enables per bit and a
// three-sample majority vote around mid-bit. Completed frames are pushed into
// a show-ahead FIFO together with their parity/framing error tags. Break
// conditions and FIFO overflows are reported through sticky flags.
//
// Parameters
//   OSR            baud_tick pulses per bit (even, 8..32)
//   FIFO_DEPTH     receive FIFO entries (power of 2, 2..64)
//
// Ports
//   clk, reset_n         system clock, asynchronous active-low reset
//   baud_tick            one-clk enable at OSR x baud rate
//   rx                   asynchronous serial input, idle high
//   data_bits            00=5, 01=6, 10=7, 11=8 data bits
//   parity_en            parity bit present
//   odd_n_even           1=odd parity, 0=even parity
//   two_stop             1=two stop bits expected
//   rd_en                pop the FIFO head
//   clear_status         clear overflow and break_det
//   rd_data              FIFO head data, zero-extended above the data width
//   rd_parity_err        parity error tag of the FIFO head
//   rd_framing_err       framing error tag of the FIFO head
//   empty, full, level   FIFO status and occupancy
//   overflow             sticky: a frame was dropped on a full FIFO
//   break_det            sticky: a break was received
//   rx_busy              frame state machine is not idle
// ---------------------------------------------------------------------------
module uart_rx_ext #(
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          baud_tick,
  input  logic                          rx,
  input  logic [1:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          odd_n_even,
  input  logic                          two_stop,
  input  logic                          rd_en,
  input  logic                          clear_status,
  output logic [7:0]                    rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_framing_err,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          break_det,
  output logic                          rx_busy
);

  localparam int CW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // Sample points of the three-way majority vote and the bit boundary.
  localparam logic [CW-1:0] C_S0  = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] C_S1  = CW'(OSR / 2);
  localparam logic [CW-1:0] C_MID = CW'(OSR / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(OSR - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser. r_live flushes the synchroniser's reset value so a
  // line held low through reset is never mistaken for "sampled high".
  // ---------------------------------------------------------------------
  logic [1:0] r_sync;
  logic [1:0] r_live;
  logic       w_rx;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
      r_live <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_live <= {r_live[0], 1'b1};
    end
  end

  assign w_rx = r_sync[1];

  // ---------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg;
  logic          r_s0;
  logic          r_s1;
  logic          r_pbit;
  logic          r_ferr;
  logic          r_stop_idx;
  logic          r_armed;
  logic [1:0]    r_nbits;
  logic          r_par_en;
  logic          r_odd;
  logic          r_two_stop;

  logic          w_maj;
  logic [7:0]    w_data;
  logic [2:0]    w_last_idx;
  logic          w_last_stop;
  logic          w_break;
  logic          w_wr;
  logic          w_ferr;
  logic          w_perr;

  assign w_maj       = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  // Bits shift in from the MSB end; right-align according to the width.
  assign w_data      = r_shreg >> (2'd3 - r_nbits);
  assign w_last_idx  = {1'b0, r_nbits} + 3'd4;
  assign w_last_stop = (r_state == STOP) && (!r_two_stop || r_stop_idx);
  assign w_break     = baud_tick && (r_state == STOP) && !r_stop_idx &&
                       (r_cnt == C_MID) && !w_maj && (w_data == 8'd0) &&
                       (!r_par_en || !r_pbit);
  assign w_wr        = baud_tick && (r_cnt == C_MID) && w_last_stop && !w_break;
  assign w_ferr      = r_ferr | ~w_maj;
  assign w_perr      = r_par_en & ((^w_data) ^ r_pbit ^ r_odd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_pbit     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
      r_armed    <= 1'b0;
      r_nbits    <= 2'b00;
      r_par_en   <= 1'b0;
      r_odd      <= 1'b0;
      r_two_stop <= 1'b0;
    end else if (baud_tick) begin
      case (r_state)
        IDLE: begin
          if (w_rx && r_live[1]) r_armed <= 1'b1;
          if (r_armed && !w_rx) begin
            r_state    <= START;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_pbit     <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop_idx <= 1'b0;
            r_nbits    <= data_bits;
            r_par_en   <= parity_en;
            r_odd      <= odd_n_even;
            r_two_stop <= two_stop;
          end
        end

        BRK_WAIT: begin
          if (w_rx) r_state <= IDLE;
        end

        default: begin
          r_cnt <= (r_cnt == C_END) ? '0 : r_cnt + 1'b1;
          if (r_cnt == C_S0) r_s0 <= w_rx;
          if (r_cnt == C_S1) r_s1 <= w_rx;

          case (r_state)
            START: begin
              if (r_cnt == C_MID && w_maj) r_state <= IDLE;   // false start
              else if (r_cnt == C_END)     r_state <= DATA;
            end

            DATA: begin
              if (r_cnt == C_MID) r_shreg <= {w_maj, r_shreg[7:1]};
              if (r_cnt == C_END) begin
                if (r_bit_idx == w_last_idx) r_state <= r_par_en ? PARITY : STOP;
                else                         r_bit_idx <= r_bit_idx + 3'd1;
              end
            end

            PARITY: begin
              if (r_cnt == C_MID) r_pbit  <= w_maj;
              if (r_cnt == C_END) r_state <= STOP;
            end

            STOP: begin
              if (r_cnt == C_MID) begin
                if (w_break)          r_state <= BRK_WAIT;
                else if (w_last_stop) r_state <= IDLE;
                else                  r_ferr  <= w_ferr;
              end
              // Only reached on the first of two stop bits.
              if (r_cnt == C_END) r_stop_idx <= 1'b1;
            end

            default: r_state <= IDLE;
          endcase
        end
      endcase
    end
  end

  assign rx_busy = (r_state != IDLE);

  // ---------------------------------------------------------------------
  // Receive FIFO and sticky status
  // ---------------------------------------------------------------------
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;
  logic [9:0]    w_head;

  assign empty  = (r_level == '0);
  assign full   = (r_level == LW'(FIFO_DEPTH));
  assign level  = r_level;
  assign w_pop  = rd_en && !empty;
  // A full FIFO still accepts the write when the head is popped this cycle.
  assign w_push = w_wr && (!full || w_pop);

  // NOTE: the storage array carries no reset; its contents are meaningless
  // while empty and the outputs below are gated, so no reset tree is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_perr, w_ferr, w_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      overflow  <= 1'b0;
      break_det <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // Set has priority over clear.
      if (w_wr && full && !rd_en) overflow <= 1'b1;
      else if (clear_status)      overflow <= 1'b0;
      if (w_break)                break_det <= 1'b1;
      else if (clear_status)      break_det <= 1'b0;
    end
  end

  assign w_head         = r_mem[r_rptr];
  assign rd_data        = empty ? 8'h00 : w_head[7:0];
  assign rd_framing_err = empty ? 1'b0  : w_head[8];
  assign rd_parity_err  = empty ? 1'b0  : w_head[9];

endmodule

// File: tb/tb_uart_rx_ext.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ext -- self-checking bench for uart_rx_ext (OSR=16, depth 4)
//
// Frames are serialised bit by bit on rx; a frame-level reference model
// (queue of expected entries plus expected sticky flags) predicts FIFO
// contents, error tags, overflow and break behaviour.
// ---------------------------------------------------------------------------
module tb_uart_rx_ext;

  localparam int OSR   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] data_bits = 2'b11;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       two_stop = 1'b0;
  logic       rd_en = 1'b0;
  logic       clear_status = 1'b0;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       rd_framing_err;
  logic       empty;
  logic       full;
  logic [2:0] level;
  logic       overflow;
  logic       break_det;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  logic exp_ovf = 1'b0;
  logic exp_brk = 1'b0;

  uart_rx_ext #(.OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .baud_tick      (baud_tick),
    .rx             (rx),
    .data_bits      (data_bits),
    .parity_en      (parity_en),
    .odd_n_even     (odd_n_even),
    .two_stop       (two_stop),
    .rd_en          (rd_en),
    .clear_status   (clear_status),
    .rd_data        (rd_data),
    .rd_parity_err  (rd_parity_err),
    .rd_framing_err (rd_framing_err),
    .empty          (empty),
    .full           (full),
    .level          (level),
    .overflow       (overflow),
    .break_det      (break_det),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  // baud_tick every second clock, changed just after the rising edge.
  initial begin
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n = (n + 1) % 2;
      baud_tick = (n == 0);
    end
  end

  // Returns on the falling edge that precedes a tick edge.
  task automatic wait_tick();
    do @(negedge clk); while (!baud_tick);
  endtask

  task automatic hold_rx(input logic b, input int ticks);
    rx = b;
    repeat (ticks) wait_tick();
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    exp_ovf = 1'b0;
    exp_brk = 1'b0;
  endtask

  // Frame-level reference: what a receiver should make of one frame.
  task automatic model_frame(input logic [7:0] d, input int nb, input logic pe,
                             input logic odd, input logic pbit, input logic two,
                             input logic s0, input logic s1);
    logic [7:0] dm;
    int         ones;
    exp_t       e;
    dm   = d & 8'((1 << nb) - 1);
    ones = $countones(dm) + int'(pbit);
    if (dm == 8'd0 && (!pe || !pbit) && !s0) begin
      exp_brk = 1'b1;
    end else begin
      e.data = dm;
      e.ferr = !s0 || (two && !s1);
      e.perr = pe && (odd ? (ones % 2 == 0) : (ones % 2 == 1));
      if (q.size() == DEPTH) exp_ovf = 1'b1;
      else                   q.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] db,
                            input logic pe, input logic odd, input logic pbit,
                            input logic two, input logic s0, input logic s1);
    int nb;
    nb = int'(db) + 5;
    data_bits  = db;
    parity_en  = pe;
    odd_n_even = odd;
    two_stop   = two;
    model_frame(d, nb, pe, odd, pbit, two, s0, s1);
    hold_rx(1'b0, OSR);
    for (int i = 0; i < nb; i++) hold_rx(d[i], OSR);
    if (pe)  hold_rx(pbit, OSR);
    hold_rx(s0, OSR);
    if (two) hold_rx(s1, OSR);
    hold_rx(1'b1, 2 * OSR);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL %s_empty: got %b want 1", tag, empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL %s_full: got %b want 0", tag, full); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL %s_level: got %0d want 0", tag, level); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL %s_rd_data: got %h want 00", tag, rd_data); end
    checks++; if ({rd_parity_err, rd_framing_err} !== 2'b00) begin errors++; $display("FAIL %s_tags: got %b want 00", tag, {rd_parity_err, rd_framing_err}); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL %s_overflow: got %b want 0", tag, overflow); end
    checks++; if (break_det !== 1'b0) begin errors++; $display("FAIL %s_break: got %b want 0", tag, break_det); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b want 0", tag, rx_busy); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    hold_rx(1'b1, 2 * OSR);
  endtask

  task automatic test_basic_8n1();
    send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b want 0", empty); end
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", rd_data); end
    checks++; if ({rd_parity_err, rd_framing_err} !== {q[0].perr, q[0].ferr}) begin errors++; $display("FAIL basic_tags: got %b want %b", {rd_parity_err, rd_framing_err}, {q[0].perr, q[0].ferr}); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d want 1", level); end
    pop();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_pop_empty: got %b want 1", empty); end
  endtask

  task automatic test_parity_7e1();
    send_frame(8'h41, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h41, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL parity_level: got %0d want %0d", level, q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rd_data !== q[0].data) begin errors++; $display("FAIL parity_data%0d: got %h want %h", i, rd_data, q[0].data); end
      checks++; if (rd_parity_err !== q[0].perr) begin errors++; $display("FAIL parity_err%0d: got %b want %b", i, rd_parity_err, q[0].perr); end
      pop();
    end
  endtask

  task automatic test_false_start();
    hold_rx(1'b0, 4);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", rx_busy); end
    hold_rx(1'b1, 2 * OSR);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL glitch_empty: got %b want 1", empty); end
    checks++; if ({overflow, break_det} !== 2'b00) begin errors++; $display("FAIL glitch_flags: got %b want 00", {overflow, break_det}); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++)
      send_frame(8'(i), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", level); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag: got %b want %b", overflow, exp_ovf); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rd_data !== q[0].data) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", i, rd_data, q[0].data); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b want 1", empty); end
    pulse_clear();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_framing_break();
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL frm_data: got %h want 3c", rd_data); end
    checks++; if (rd_framing_err !== q[0].ferr) begin errors++; $display("FAIL frm_err: got %b want %b", rd_framing_err, q[0].ferr); end
    pop();
    // 12 bit times low with 8N2 latched: a break.
    hold_rx(1'b0, 12 * OSR);
    exp_brk = 1'b1;
    checks++; if (break_det !== exp_brk) begin errors++; $display("FAIL brk_flag: got %b want 1", break_det); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL brk_level: got %0d want 0", level); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL brk_busy: got %b want 1", rx_busy); end
    hold_rx(1'b1, 4);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL brk_release: got %b want 0", rx_busy); end
    hold_rx(1'b1, OSR);
    pulse_clear();
    checks++; if (break_det !== 1'b0) begin errors++; $display("FAIL brk_clear: got %b want 0", break_det); end
  endtask

  task automatic test_random();
    logic [7:0] d, dm;
    logic [1:0] db;
    logic       pe, odd, two, good, pbit, s0, s1;
    int         k;
    for (int f = 0; f < 14; f++) begin
      d   = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      db  = 2'($urandom_range(0, 3));
      pe  = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      two = 1'($urandom_range(0, 1));
      dm  = d & 8'((1 << (int'(db) + 5)) - 1);
      good = odd ? ~(^dm) : ^dm;
      pbit = ($urandom_range(0, 3) == 0) ? ~good : good;
      s0  = ($urandom_range(0, 3) != 0);
      s1  = ($urandom_range(0, 3) != 0);
      send_frame(d, db, pe, odd, pbit, two, s0, s1);
      checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rand%0d_level: got %0d want %0d", f, level, q.size()); end
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rand%0d_ovf: got %b want %b", f, overflow, exp_ovf); end
      checks++; if (break_det !== exp_brk) begin errors++; $display("FAIL rand%0d_brk: got %b want %b", f, break_det, exp_brk); end
      k = $urandom_range(0, 2);
      for (int r = 0; r < k && q.size() > 0; r++) begin
        checks++; if ({rd_parity_err, rd_framing_err, rd_data} !== q[0]) begin errors++; $display("FAIL rand%0d_head: got %b_%b_%h want %b_%b_%h", f, rd_parity_err, rd_framing_err, rd_data, q[0].perr, q[0].ferr, q[0].data); end
        pop();
      end
    end
    while (q.size() > 0) begin
      checks++; if ({rd_parity_err, rd_framing_err, rd_data} !== q[0]) begin errors++; $display("FAIL rand_drain: got %b_%b_%h want %b_%b_%h", rd_parity_err, rd_framing_err, rd_data, q[0].perr, q[0].ferr, q[0].data); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rand_empty: got %b want 1", empty); end
    pulse_clear();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hA5;
    send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    hold_rx(1'b0, OSR);
    for (int i = 0; i < 4; i++) hold_rx(d[i], OSR);
    hold_rx(d[4], OSR / 2);
    reset_n = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    exp_brk = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    // Release with the line low: nothing may start until rx is seen high.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    hold_rx(1'b0, 3 * OSR);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_low_busy: got %b want 0", rx_busy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_low_empty: got %b want 1", empty); end
    hold_rx(1'b1, OSR);
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL midrst_level: got %0d want 1", level); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL midrst_data: got %h want 3c", rd_data); end
    pop();
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity_7e1();
    test_false_start();
    test_overflow();
    test_framing_break();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
